seq_acc_drain: RTL and testbench
================================

Name: seq_acc_drain

Overview:
- Output-side consumer for the sequential MAC accumulator.
- Captures the full accumulator vector on each single-cycle valid pulse. The upstream cannot be stalled, so it has no ready.
- Requantizes each element by a per-result arithmetic right shift with signed saturation.
- Serializes the result as narrow beats over a valid/ready stream toward the output buffer.
- Provides two-entry ping-pong buffering so one result can drain while the next completes.

Parameters:
- outputElements, 32, accumulator lanes per result
- accumulatorBits, 16, signed width of each accumulator lane
- outBits, 8, signed width of each requantized output lane
- lanesPerBeat, 4, output lanes per stream beat; must divide outputElements
- numBeats, outputElements/lanesPerBeat (localparam), beats per result
- shiftBits, $clog2(accumulatorBits) (localparam), width of the shift amount

Ports:
- clk, in, 1, clock
- nrst, in, 1, reset: synchronous, active-low
- acc_valid_i, in, 1, single-cycle pulse marking acc_data_i valid
- acc_data_i, in, [outputElements][accumulatorBits], signed accumulator vector
- shift_i, in, shiftBits, requant right-shift amount; sampled with acc_valid_i
- out_valid_o, out, 1, stream beat valid
- out_ready_i, in, 1, stream beat accepted
- out_data_o, out, [lanesPerBeat][outBits], requantized lanes; lane j = element beat*lanesPerBeat+j
- out_last_o, out, 1, marks the final beat of a result
- out_beat_o, out, $clog2(numBeats), index of the current beat
- busy_o, out, 1, at least one buffer entry occupied
- overflow_o, out, 1, sticky flag: a result was dropped
- clr_overflow_i, in, 1, clears overflow_o

Behaviour:
- Reset (nrst low at a clk edge): both entries empty; write pointer, read pointer and beat counter = 0; out_valid_o=0, out_last_o=0, out_beat_o=0, busy_o=0, overflow_o=0, out_data_o=0. Reset mid-stream discards all buffered data; no partial beat is emitted after reset.
- Storage: 2 entries, each holding outputElements x accumulatorBits plus a shiftBits shift value; a full flag per entry; 1-bit write pointer and 1-bit read pointer.
- Capture:
  - On an edge with acc_valid_i=1 and entry[wptr] free: store acc_data_i and shift_i, set full, toggle wptr.
  - An entry whose last beat completes (out_valid_o && out_ready_i && out_last_o) on the same edge counts as free, so the capture is accepted.
  - Otherwise the result is dropped, overflow_o is set, and the pointers are unchanged.
- Overflow flag: cleared by clr_overflow_i. If a set event and clr_overflow_i occur together, the set wins.
- FSM:
  - States: IDLE, STREAM.
  - IDLE to STREAM when entry[rptr] is full.
  - In STREAM, out_valid_o=1.
  - Each handshake increments the beat counter.
  - On the beat == numBeats-1 handshake: clear entry[rptr], toggle rptr, reset beat to 0. Then go to STREAM if the other entry is full, else IDLE.
  - Back-to-back results stream with no bubble cycle.
- Latency: a capture at edge t produces out_valid_o=1 in the cycle after edge t, provided the stream was idle.
- Output rules: out_data_o, out_last_o and out_beat_o are combinational from entry[rptr] and the beat counter. They are stable while out_valid_o && !out_ready_i (AXI-style hold). out_last_o = (beat == numBeats-1) && out_valid_o.
- Requant, per lane:
  - y = x >>> shift (arithmetic shift, sign preserved, floor rounding).
  - Saturate to [-2^(outBits-1), 2^(outBits-1)-1].
  - shift is the value stored with that entry, not the live shift_i.
- busy_o = either entry full.

Test Plan:
- Single result: acc lanes k = 16*k-256, shift_i=4, out_ready_i held 1.
  - Expect out_valid_o the cycle after capture.
  - 8 consecutive beats, out_last_o on beat 7.
  - Lane 0 = -16, lane 31 = 15.
- Saturation and sign: lanes {32767, -32768, -1, 5}, shift 0 then shift 15.
  - Shift 0: {127, -128, -1, 5}.
  - Shift 15: {0, -1, -1, 0}.
- Backpressure: out_ready_i toggling 1,0,0,1 pattern.
  - Data, beat index and last stay stable while stalled.
  - All 8 beats delivered in order, none duplicated.
- Ping-pong and overflow:
  - Three captures 2 cycles apart with out_ready_i=0: first two are buffered, the third is dropped and overflow_o=1.
  - Raise out_ready_i: 16 beats from results 1 and 2 with no bubble.
  - clr_overflow_i clears the flag.
- Free-on-same-edge: capture pulse coincides with the final-beat handshake while both entries are full.
  - Accepted, overflow_o stays 0, the new result streams next.
- Reset mid-stream: nrst low at beat 3.
  - Next cycle out_valid_o=0, busy_o=0, out_beat_o=0.
  - A fresh capture streams from beat 0.

Source files
------------

// File: rtl/seq_acc_drain.sv
// seq_acc_drain: two-entry ping-pong capture of accumulator vectors, requantized
// (arithmetic shift + signed saturation) and streamed out as narrow valid/ready beats.
module seq_acc_drain #(
   parameter  int outputElements  = 32,
   parameter  int accumulatorBits = 16,
   parameter  int outBits         = 8,
   parameter  int lanesPerBeat    = 4,
   localparam int numBeats        = outputElements / lanesPerBeat,
   localparam int shiftBits       = $clog2(accumulatorBits),
   localparam int beatBits        = numBeats > 1 ? $clog2(numBeats) : 1
) (
   input  logic                                            clk,
   input  logic                                            nrst,
   input  logic                                            acc_valid_i,
   input  logic [outputElements-1:0][accumulatorBits-1:0]  acc_data_i,
   input  logic [shiftBits-1:0]                            shift_i,
   output logic                                            out_valid_o,
   input  logic                                            out_ready_i,
   output logic [lanesPerBeat-1:0][outBits-1:0]            out_data_o,
   output logic                                            out_last_o,
   output logic [beatBits-1:0]                             out_beat_o,
   output logic                                            busy_o,
   output logic                                            overflow_o,
   input  logic                                            clr_overflow_i
);
   typedef enum logic {IDLE, STREAM} state_t;
   typedef logic [numBeats-1:0][lanesPerBeat-1:0][accumulatorBits-1:0] vec_t;
   localparam logic signed [accumulatorBits-1:0] sat_hi = accumulatorBits'(2 ** (outBits - 1) - 1);
   localparam logic signed [accumulatorBits-1:0] sat_lo = ~sat_hi;
   state_t                r_state, w_next_state;
   vec_t                  r_data  [2];
   logic [shiftBits-1:0]  r_shift [2];
   logic [1:0]            r_full, w_full_next;
   logic                  r_wptr, r_rptr, r_ovf;
   logic [beatBits-1:0]   r_beat;
   logic                  w_done, w_cap, w_drop, w_rptr_next;
   vec_t                  w_vec;
   logic [shiftBits-1:0]  w_shift;
   assign w_vec       = r_data[r_rptr];
   assign w_shift     = r_shift[r_rptr];
   assign w_done      = out_valid_o && out_ready_i && out_last_o;
   // an entry draining its last beat on this edge may be refilled on the same edge
   assign w_cap       = acc_valid_i && (!r_full[r_wptr] || (w_done && r_wptr == r_rptr));
   assign w_drop      = acc_valid_i && !w_cap;
   assign w_rptr_next = r_rptr ^ w_done;
   always_comb begin
      w_full_next = r_full;
      if (w_done) w_full_next[r_rptr] = 1'b0;
      if (w_cap) w_full_next[r_wptr] = 1'b1;
   end
   // looking at next-cycle occupancy lets a fresh capture stream the following cycle
   always_comb begin
      w_next_state = r_state;
      out_valid_o  = r_state == STREAM;
      w_next_state = r_state == IDLE ? (w_full_next[r_rptr] ? STREAM : IDLE)
                                     : ((w_done && !w_full_next[w_rptr_next]) ? IDLE : STREAM);
   end
   assign out_last_o = out_valid_o && r_beat == beatBits'(numBeats - 1);
   assign out_beat_o = r_beat;
   assign busy_o     = |r_full;
   assign overflow_o = r_ovf;
   for (genvar j = 0; j < lanesPerBeat; j++) begin : g_lane
      logic signed [accumulatorBits-1:0] w_x, w_y;
      assign w_x = w_vec[r_beat][j];
      assign w_y = w_x >>> w_shift;
      assign out_data_o[j] = !out_valid_o ? '0
                           : w_y > sat_hi ? sat_hi[outBits-1:0]
                           : w_y < sat_lo ? sat_lo[outBits-1:0]
                           : w_y[outBits-1:0];
   end
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= IDLE;
         r_full  <= '0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_beat  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_full  <= w_full_next;
         r_wptr  <= r_wptr ^ w_cap;
         r_rptr  <= w_rptr_next;
         if (out_valid_o && out_ready_i) r_beat <= w_done ? '0 : r_beat + 1'b1;
         r_ovf   <= w_drop || (r_ovf && !clr_overflow_i);
      end
   end
   always_ff @(posedge clk) begin
      if (w_cap) begin
         r_data[r_wptr]  <= vec_t'(acc_data_i);
         r_shift[r_wptr] <= shift_i;
      end
   end
endmodule

// File: tb/tb_seq_acc_drain.sv
// tb_seq_acc_drain: randomized scenarios checked against a queue-based model of the
// drain (capture order, per-beat requantization, overflow flag).
module tb_seq_acc_drain;
   localparam int NE = 32, AB = 16, OB = 8, LPB = 4, NB = 8, SB = 4, BB = 3;
   logic clk = 0, nrst = 0, acc_valid_i = 0, out_ready_i = 0, clr_overflow_i = 0;
   logic [NE-1:0][AB-1:0] acc_data_i = '0;
   logic [SB-1:0] shift_i = '0;
   logic out_valid_o, out_last_o, busy_o, overflow_o;
   logic [LPB-1:0][OB-1:0] out_data_o;
   logic [BB-1:0] out_beat_o;
   int checks = 0, errors = 0;
   typedef struct {int v[NE]; int sh;} res_t;
   res_t m_q[$];
   int m_beat = 0;
   bit m_ovf = 0;

   seq_acc_drain dut (
      .clk(clk), .nrst(nrst), .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i),
      .shift_i(shift_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_last_o(out_last_o), .out_beat_o(out_beat_o),
      .busy_o(busy_o), .overflow_o(overflow_o), .clr_overflow_i(clr_overflow_i));

   always #5 clk = ~clk;

   function automatic int rq(int x, int sh);
      int y;
      y = x >>> sh;
      return y > 127 ? 127 : (y < -128 ? -128 : y);
   endfunction

   function automatic logic [LPB*OB-1:0] exp_data();
      logic [LPB*OB-1:0] d = '0;
      int t;
      if (m_q.size() == 0) return d;
      for (int j = 0; j < LPB; j++) begin
         t = rq(m_q[0].v[m_beat*LPB+j], m_q[0].sh);
         d[j*OB +: OB] = t[OB-1:0];
      end
      return d;
   endfunction

   function automatic logic [4:0] exp_ctl();
      bit v;
      v = m_q.size() > 0;
      return {v, v && m_beat == NB-1, 3'(m_beat)};
   endfunction

   task automatic tick();
      res_t r;
      bit hs, set;
      hs = m_q.size() > 0 && out_ready_i;
      set = 0;
      if (!nrst) begin
         m_q.delete();
         m_beat = 0;
         m_ovf = 0;
      end else begin
         if (hs) begin
            if (m_beat == NB-1) begin
               m_q.delete(0);
               m_beat = 0;
            end else m_beat++;
         end
         if (acc_valid_i) begin
            if (m_q.size() < 2) begin
               for (int k = 0; k < NE; k++) r.v[k] = int'($signed(acc_data_i[k]));
               r.sh = int'(shift_i);
               m_q.push_back(r);
            end else set = 1;
         end
         m_ovf = set ? 1'b1 : (clr_overflow_i ? 1'b0 : m_ovf);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_acc();
      for (int k = 0; k < NE; k++) acc_data_i[k] = AB'($urandom);
      shift_i = SB'($urandom);
   endtask

   task automatic capture();
      acc_valid_i = 1;
      tick();
      acc_valid_i = 0;
   endtask

   task automatic test_reset();
      nrst = 0;
      tick();
      tick();
      checks += 4;
      if ({out_valid_o, out_last_o, out_beat_o} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b want 00000", {out_valid_o, out_last_o, out_beat_o}); end
      if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
      if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
      if (out_data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", out_data_o); end
      nrst = 1;
      tick();
   endtask

   task automatic test_single();
      out_ready_i = 1;
      for (int k = 0; k < NE; k++) acc_data_i[k] = AB'(16*k - 256);
      shift_i = 4;
      capture();
      checks++;
      if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", out_valid_o); end
      for (int b = 0; b < NB; b++) begin
         checks += 2;
         if ({out_valid_o, out_last_o, out_beat_o} !== exp_ctl()) begin errors++; $display("FAIL single_ctl beat %0d got %b want %b", b, {out_valid_o, out_last_o, out_beat_o}, exp_ctl()); end
         if (out_data_o !== exp_data()) begin errors++; $display("FAIL single_data beat %0d got %h want %h", b, out_data_o, exp_data()); end
         if (b == 0) begin checks++; if (out_data_o[0] !== 8'hF0) begin errors++; $display("FAIL single_lane0 got %h want f0", out_data_o[0]); end end
         if (b == NB-1) begin checks++; if (out_data_o[3] !== 8'h0F) begin errors++; $display("FAIL single_lane31 got %h want 0f", out_data_o[3]); end end
         tick();
      end
      checks++;
      if ({out_valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL single_done got %b want 00", {out_valid_o, busy_o}); end
   endtask

   task automatic test_saturation();
      logic [31:0] want [2] = '{32'h05FF807F, 32'h00FFFF00};
      out_ready_i = 1;
      for (int s = 0; s < 2; s++) begin
         rand_acc();
         acc_data_i[0] = 16'h7FFF;
         acc_data_i[1] = 16'h8000;
         acc_data_i[2] = 16'hFFFF;
         acc_data_i[3] = 16'd5;
         shift_i = s == 0 ? 4'd0 : 4'd15;
         capture();
         checks++;
         if (out_data_o !== want[s]) begin errors++; $display("FAIL sat_shift%0d got %h want %h", s == 0 ? 0 : 15, out_data_o, want[s]); end
         for (int c = 0; c < 20 && m_q.size() > 0; c++) begin
            checks++;
            if ({out_valid_o, out_last_o, out_beat_o, out_data_o} !== {exp_ctl(), exp_data()}) begin errors++; $display("FAIL sat_stream got %b/%h want %b/%h", {out_valid_o, out_last_o, out_beat_o}, out_data_o, exp_ctl(), exp_data()); end
            tick();
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pat = 4'b1001;
      int hs = 0;
      out_ready_i = 0;
      rand_acc();
      capture();
      for (int c = 0; c < 40 && m_q.size() > 0; c++) begin
         out_ready_i = pat[c%4];
         checks++;
         if ({out_valid_o, out_last_o, out_beat_o} !== exp_ctl()) begin errors++; $display("FAIL bp_ctl cyc %0d got %b want %b", c, {out_valid_o, out_last_o, out_beat_o}, exp_ctl()); end
         if (m_q.size() > 0) begin
            checks++;
            if (out_data_o !== exp_data()) begin errors++; $display("FAIL bp_data cyc %0d got %h want %h", c, out_data_o, exp_data()); end
         end
         if (out_valid_o && out_ready_i) hs++;
         tick();
      end
      checks++;
      if (hs !== NB) begin errors++; $display("FAIL bp_beats got %0d want %0d", hs, NB); end
      out_ready_i = 1;
   endtask

   task automatic test_pingpong();
      out_ready_i = 0;
      rand_acc(); capture(); tick();
      rand_acc(); capture(); tick();
      rand_acc();
      clr_overflow_i = 1;
      capture();
      clr_overflow_i = 0;
      checks += 2;
      if (overflow_o !== 1'b1 || m_ovf !== 1'b1) begin errors++; $display("FAIL pp_ovf got %b want 1", overflow_o); end
      if (busy_o !== 1'b1) begin errors++; $display("FAIL pp_busy got %b want 1", busy_o); end
      out_ready_i = 1;
      for (int c = 0; c < 2*NB; c++) begin
         checks += 2;
         if (out_valid_o !== 1'b1) begin errors++; $display("FAIL pp_bubble cyc %0d got %b want 1", c, out_valid_o); end
         if ({out_valid_o, out_last_o, out_beat_o, out_data_o} !== {exp_ctl(), exp_data()}) begin errors++; $display("FAIL pp_stream cyc %0d got %b/%h want %b/%h", c, {out_valid_o, out_last_o, out_beat_o}, out_data_o, exp_ctl(), exp_data()); end
         tick();
      end
      checks++;
      if ({out_valid_o, busy_o, overflow_o} !== 3'b001) begin errors++; $display("FAIL pp_drained got %b want 001", {out_valid_o, busy_o, overflow_o}); end
      clr_overflow_i = 1;
      tick();
      clr_overflow_i = 0;
      checks++;
      if (overflow_o !== 1'b0) begin errors++; $display("FAIL pp_clr got %b want 0", overflow_o); end
   endtask

   task automatic test_free_same_edge();
      int vc = 0;
      out_ready_i = 0;
      rand_acc(); capture();
      rand_acc(); capture();
      out_ready_i = 1;
      for (int c = 0; c < 20 && !(m_q.size() == 2 && m_beat == NB-1); c++) tick();
      checks++;
      if (out_last_o !== 1'b1) begin errors++; $display("FAIL fse_last got %b want 1", out_last_o); end
      rand_acc();
      capture();
      checks += 2;
      if (overflow_o !== 1'b0) begin errors++; $display("FAIL fse_ovf got %b want 0", overflow_o); end
      if ({out_valid_o, busy_o, out_beat_o} !== {2'b11, 3'd0}) begin errors++; $display("FAIL fse_next got %b want 11000", {out_valid_o, busy_o, out_beat_o}); end
      for (int c = 0; c < 40 && m_q.size() > 0; c++) begin
         checks++;
         if ({out_valid_o, out_last_o, out_beat_o, out_data_o} !== {exp_ctl(), exp_data()}) begin errors++; $display("FAIL fse_stream cyc %0d got %b/%h want %b/%h", c, {out_valid_o, out_last_o, out_beat_o}, out_data_o, exp_ctl(), exp_data()); end
         if (out_valid_o) vc++;
         tick();
      end
      checks++;
      if (vc !== 2*NB) begin errors++; $display("FAIL fse_beats got %0d want %0d", vc, 2*NB); end
   endtask

   task automatic test_reset_mid();
      out_ready_i = 1;
      rand_acc(); capture();
      for (int c = 0; c < 10 && m_beat != 3; c++) tick();
      checks++;
      if (out_beat_o !== 3'd3) begin errors++; $display("FAIL rm_beat3 got %0d want 3", out_beat_o); end
      nrst = 0;
      tick();
      checks++;
      if ({out_valid_o, busy_o, out_beat_o} !== 5'b0) begin errors++; $display("FAIL rm_after got %b want 00000", {out_valid_o, busy_o, out_beat_o}); end
      nrst = 1;
      rand_acc(); capture();
      for (int c = 0; c < 20 && m_q.size() > 0; c++) begin
         checks++;
         if ({out_valid_o, out_last_o, out_beat_o, out_data_o} !== {exp_ctl(), exp_data()}) begin errors++; $display("FAIL rm_stream cyc %0d got %b/%h want %b/%h", c, {out_valid_o, out_last_o, out_beat_o}, out_data_o, exp_ctl(), exp_data()); end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rand_acc();
         acc_valid_i = $urandom_range(0, 4) == 0;
         out_ready_i = $urandom_range(0, 3) != 0;
         clr_overflow_i = $urandom_range(0, 15) == 0;
         checks += 2;
         if ({out_valid_o, out_last_o, out_beat_o} !== exp_ctl()) begin errors++; $display("FAIL rnd_ctl cyc %0d got %b want %b", c, {out_valid_o, out_last_o, out_beat_o}, exp_ctl()); end
         if ({busy_o, overflow_o} !== {m_q.size() > 0, m_ovf}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b want %b", c, {busy_o, overflow_o}, {m_q.size() > 0, m_ovf}); end
         if (m_q.size() > 0) begin
            checks++;
            if (out_data_o !== exp_data()) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, out_data_o, exp_data()); end
         end
         tick();
      end
      acc_valid_i = 0;
      clr_overflow_i = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_saturation();
      test_backpressure();
      test_pingpong();
      test_free_same_edge();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
